// File: rtl/pipe_fwd_chain_pkg.sv
// Shared definitions for the pipeline forwarding chain: default widths,
// the x0 register index and the forward-candidate predicate.
package pipe_fwd_chain_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_REG_AW   = 5;
  localparam int DEF_CTRL_W   = 8;
  localparam int DEF_DEPTH    = 2;
  localparam int DEF_LD_STAGE = 1;

  // Architectural zero register; writes to it never forward or retire.
  localparam int X0 = 0;

  // An entry is a forward candidate when it is live, writes a register,
  // targets the requested source and that source is not x0.
  function automatic logic fwd_cand(input logic v, input logic we,
                                    input logic rd_eq, input logic rs_nz);
    return v & we & rd_eq & rs_nz;
  endfunction

endpackage

// File: rtl/pipe_fwd_chain_if.sv
// Issue / forward / retire bundle between ID/EX issue logic, the chain and
// the regfile write port. master = upstream driver, slave = the chain.
interface pipe_fwd_chain_if
  import pipe_fwd_chain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DEPTH  = DEF_DEPTH
) ();

  logic              stall;
  logic [DEPTH-1:0]  flush;
  logic              iss_valid;
  logic [REG_AW-1:0] iss_rd;
  logic              iss_we;
  logic              iss_is_ld;
  logic [DATA_W-1:0] iss_data;
  logic [CTRL_W-1:0] iss_ctrl;
  logic [DATA_W-1:0] ld_data;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic              rs1_hit;
  logic [DATA_W-1:0] rs1_data;
  logic              rs2_hit;
  logic [DATA_W-1:0] rs2_data;
  logic              hazard;
  logic              ret_valid;
  logic [REG_AW-1:0] ret_rd;
  logic [DATA_W-1:0] ret_data;
  logic [CTRL_W-1:0] ret_ctrl;
  logic [DEPTH-1:0]  stage_valid;

  modport master (
    output stall, flush, iss_valid, iss_rd, iss_we, iss_is_ld, iss_data,
           iss_ctrl, ld_data, rs1_addr, rs2_addr,
    input  rs1_hit, rs1_data, rs2_hit, rs2_data, hazard,
           ret_valid, ret_rd, ret_data, ret_ctrl, stage_valid
  );

  modport slave (
    input  stall, flush, iss_valid, iss_rd, iss_we, iss_is_ld, iss_data,
           iss_ctrl, ld_data, rs1_addr, rs2_addr,
    output rs1_hit, rs1_data, rs2_hit, rs2_data, hazard,
           ret_valid, ret_rd, ret_data, ret_ctrl, stage_valid
  );

endinterface

// File: rtl/pipe_fwd_chain_stage.sv
// One pipeline entry register with hold (stall), flush and, for the load
// stage, substitution of the arriving load data into its effective value.
module pipe_fwd_chain_stage
  import pipe_fwd_chain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter bit IS_LD  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              d_v,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_we,
  input  logic              d_rdy,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              q_v,
  output logic [REG_AW-1:0] q_rd,
  output logic              q_we,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic              eff_avail,
  output logic [DATA_W-1:0] eff_data
);

  logic              q_rdy;
  logic [DATA_W-1:0] q_data;

  // Entry register: load when advancing, hold when stalled; flush kills v either way.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_v    <= 1'b0;
      q_rd   <= '0;
      q_we   <= 1'b0;
      q_rdy  <= 1'b0;
      q_data <= '0;
      q_ctrl <= '0;
    end else begin
      if (!hold) begin
        q_v    <= d_v;
        q_rd   <= d_rd;
        q_we   <= d_we;
        q_rdy  <= d_rdy;
        q_data <= d_data;
        q_ctrl <= d_ctrl;
      end
      if (flush) q_v <= 1'b0;
    end
  end

  // Effective value: stored result, or live load data while a pending load sits here.
  always_comb begin
    eff_avail = q_v & (q_rdy | IS_LD);
    eff_data  = '0;
    if (q_rdy)            eff_data = q_data;
    else if (IS_LD && q_v) eff_data = ld_data;
  end

endmodule

// File: rtl/pipe_fwd_chain.sv
// Parametrised pipeline register chain: carries rd/we/result/sideband through
// DEPTH stages, forwards the youngest matching result to rs1/rs2, interlocks
// on load-use and retires the oldest stage to the regfile.
module pipe_fwd_chain
  import pipe_fwd_chain_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LD_STAGE = DEF_LD_STAGE
) (
  input logic            clk,
  input logic            reset,
  pipe_fwd_chain_if.slave bus
);

  localparam int LAST = DEPTH - 1;

  // Stage outputs (index 0 youngest).
  logic [DEPTH-1:0]             vld_pipe;
  logic [DEPTH-1:0]             s_we;
  logic [DEPTH-1:0]             s_avail;
  logic [DEPTH-1:0][REG_AW-1:0] s_rd;
  logic [DEPTH-1:0][DATA_W-1:0] s_eff;
  logic [DEPTH-1:0][CTRL_W-1:0] s_ctrl;

  // Stage inputs.
  logic [DEPTH-1:0]             d_v;
  logic [DEPTH-1:0]             d_we;
  logic [DEPTH-1:0]             d_rdy;
  logic [DEPTH-1:0][REG_AW-1:0] d_rd;
  logic [DEPTH-1:0][DATA_W-1:0] d_data;
  logic [DEPTH-1:0][CTRL_W-1:0] d_ctrl;

  logic                         hazard;

  if (DEPTH < 1 || LD_STAGE < 0 || LD_STAGE >= DEPTH) begin : g_param_bad
    $error("pipe_fwd_chain: need DEPTH>=1 and 0<=LD_STAGE<DEPTH");
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Hazard turns the issue slot into a bubble; upstream re-presents it.
      assign d_v[k]    = bus.iss_valid & ~hazard;
      assign d_rd[k]   = bus.iss_rd;
      assign d_we[k]   = bus.iss_we;
      assign d_rdy[k]  = ~bus.iss_is_ld;
      assign d_data[k] = bus.iss_data;
      assign d_ctrl[k] = bus.iss_ctrl;
    end else begin : g_body
      // Passing the effective value makes a load capture ld_data as it leaves LD_STAGE.
      assign d_v[k]    = vld_pipe[k-1];
      assign d_rd[k]   = s_rd[k-1];
      assign d_we[k]   = s_we[k-1];
      assign d_rdy[k]  = s_avail[k-1];
      assign d_data[k] = s_eff[k-1];
      assign d_ctrl[k] = s_ctrl[k-1];
    end

    pipe_fwd_chain_stage #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .CTRL_W (CTRL_W),
      .IS_LD  (k == LD_STAGE)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .hold      (bus.stall),
      .flush     (bus.flush[k]),
      .d_v       (d_v[k]),
      .d_rd      (d_rd[k]),
      .d_we      (d_we[k]),
      .d_rdy     (d_rdy[k]),
      .d_data    (d_data[k]),
      .d_ctrl    (d_ctrl[k]),
      .ld_data   (bus.ld_data),
      .q_v       (vld_pipe[k]),
      .q_rd      (s_rd[k]),
      .q_we      (s_we[k]),
      .q_ctrl    (s_ctrl[k]),
      .eff_avail (s_avail[k]),
      .eff_data  (s_eff[k])
    );
  end

  logic [1:0][REG_AW-1:0] rs_addr;
  logic [1:0]             found;
  logic [1:0]             win_av;
  logic [1:0][DATA_W-1:0] win_data;
  logic [1:0]             fwd_hit;
  logic [1:0][DATA_W-1:0] fwd_data;

  assign rs_addr = {bus.rs2_addr, bus.rs1_addr};

  // Priority select per source: scan oldest to youngest so the youngest match wins.
  always_comb begin
    found    = '0;
    win_av   = '0;
    win_data = '0;
    fwd_hit  = '0;
    fwd_data = '0;
    for (int j = 0; j < 2; j++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (fwd_cand(vld_pipe[k], s_we[k], s_rd[k] == rs_addr[j],
                     rs_addr[j] != REG_AW'(X0))) begin
          found[j]    = 1'b1;
          win_av[j]   = s_avail[k];
          win_data[j] = s_eff[k];
        end
      end
      fwd_hit[j]  = found[j] & win_av[j];
      fwd_data[j] = fwd_hit[j] ? win_data[j] : '0;
    end
  end

  // Load-use interlock: a winning match whose value does not exist yet.
  assign hazard = bus.iss_valid & |(found & ~win_av);

  assign bus.rs1_hit     = fwd_hit[0];
  assign bus.rs1_data    = fwd_data[0];
  assign bus.rs2_hit     = fwd_hit[1];
  assign bus.rs2_data    = fwd_data[1];
  assign bus.hazard      = hazard;
  assign bus.stage_valid = vld_pipe;

  // Retire the oldest stage; nothing retires on a stalled cycle or to x0.
  assign bus.ret_valid = vld_pipe[LAST] & s_we[LAST] &
                         (s_rd[LAST] != REG_AW'(X0)) & ~bus.stall;
  assign bus.ret_rd    = s_rd[LAST];
  assign bus.ret_data  = s_eff[LAST];
  assign bus.ret_ctrl  = s_ctrl[LAST];

endmodule

// File: tb/tb_pipe_fwd_chain.sv
// Directed + randomized bench for pipe_fwd_chain against a per-stage
// instruction-record model of the chain.
module tb_pipe_fwd_chain;
  localparam int DW = 32, AW = 5, CW = 8, D = 2, L = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_fwd_chain_if #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW), .DEPTH(D)) bus ();

  pipe_fwd_chain #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW), .DEPTH(D),
                   .LD_STAGE(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: one instruction record per stage.
  logic          m_v[D];
  logic          m_we[D];
  logic          m_rdy[D];
  logic [AW-1:0] m_rd[D];
  logic [DW-1:0] m_data[D];
  logic [CW-1:0] m_ctrl[D];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < D; k++) begin
      m_v[k] = 0; m_we[k] = 0; m_rdy[k] = 0; m_rd[k] = 0; m_data[k] = 0; m_ctrl[k] = 0;
    end
  endtask

  function automatic logic [DW-1:0] effd(input int k);
    if (m_rdy[k]) return m_data[k];
    if (k == L)   return bus.ld_data;
    return '0;
  endfunction

  // Youngest valid writer of rs; value known if already produced or load arrives now.
  task automatic fwd(input logic [AW-1:0] rs, output logic found, output logic hit,
                     output logic unav, output logic [DW-1:0] d);
    found = 0; hit = 0; unav = 0; d = '0;
    if (rs != 0)
      for (int k = 0; k < D; k++)
        if (!found && m_v[k] && m_we[k] && m_rd[k] == rs) begin
          found = 1;
          if (m_rdy[k] || k == L) begin hit = 1; d = effd(k); end
          else unav = 1;
        end
  endtask

  task automatic exp_hazard(output logic h);
    logic f1, h1, u1, f2, h2, u2;
    logic [DW-1:0] d1, d2;
    fwd(bus.rs1_addr, f1, h1, u1, d1);
    fwd(bus.rs2_addr, f2, h2, u2, d2);
    h = bus.iss_valid & (u1 | u2);
  endtask

  task automatic model_step();
    logic h;
    exp_hazard(h);
    if (!bus.stall) begin
      for (int k = D - 1; k >= 1; k--) begin
        m_v[k] = m_v[k-1]; m_we[k] = m_we[k-1]; m_rd[k] = m_rd[k-1];
        m_ctrl[k] = m_ctrl[k-1];
        if (k - 1 == L && !m_rdy[k-1]) begin m_data[k] = bus.ld_data; m_rdy[k] = 1; end
        else begin m_data[k] = m_data[k-1]; m_rdy[k] = m_rdy[k-1]; end
      end
      m_v[0] = bus.iss_valid & ~h; m_we[0] = bus.iss_we; m_rd[0] = bus.iss_rd;
      m_rdy[0] = ~bus.iss_is_ld; m_data[0] = bus.iss_data; m_ctrl[0] = bus.iss_ctrl;
    end
    for (int k = 0; k < D; k++) if (bus.flush[k]) m_v[k] = 0;
  endtask

  task automatic check_all();
    logic f1, h1, u1, f2, h2, u2, hz, rv;
    logic [DW-1:0] d1, d2;
    logic [D-1:0] sv;
    fwd(bus.rs1_addr, f1, h1, u1, d1);
    fwd(bus.rs2_addr, f2, h2, u2, d2);
    exp_hazard(hz);
    for (int k = 0; k < D; k++) sv[k] = m_v[k];
    chk("stage_valid", 32'(bus.stage_valid), 32'(sv));
    chk("rs1_hit", 32'(bus.rs1_hit), 32'(h1));
    if (h1 || !f1) chk("rs1_data", bus.rs1_data, d1);
    chk("rs2_hit", 32'(bus.rs2_hit), 32'(h2));
    if (h2 || !f2) chk("rs2_data", bus.rs2_data, d2);
    chk("hazard", 32'(bus.hazard), 32'(hz));
    rv = m_v[D-1] & m_we[D-1] & (m_rd[D-1] != 0) & ~bus.stall;
    chk("ret_valid", 32'(bus.ret_valid), 32'(rv));
    if (rv) begin
      chk("ret_rd", 32'(bus.ret_rd), 32'(m_rd[D-1]));
      chk("ret_data", bus.ret_data, effd(D - 1));
      chk("ret_ctrl", 32'(bus.ret_ctrl), 32'(m_ctrl[D-1]));
    end
  endtask

  task automatic sample(); @(negedge clk); check_all(); endtask

  task automatic edge_();
    @(posedge clk);
    if (!reset) model_clear(); else model_step();
    #1;
  endtask

  task automatic set_iss(input logic v, input logic [AW-1:0] rd, input logic we,
                         input logic ld, input logic [DW-1:0] data, input logic [CW-1:0] ctrl);
    bus.iss_valid = v; bus.iss_rd = rd; bus.iss_we = we;
    bus.iss_is_ld = ld; bus.iss_data = data; bus.iss_ctrl = ctrl;
  endtask

  initial begin
    bus.stall = 0; bus.flush = '0; bus.ld_data = '0;
    bus.rs1_addr = '0; bus.rs2_addr = '0;
    set_iss(0, 0, 0, 0, 0, 0);
    model_clear();

    // reset state
    @(negedge clk);
    chk("rst_stage_valid", 32'(bus.stage_valid), 0);
    chk("rst_ret_valid", 32'(bus.ret_valid), 0);
    chk("rst_ret_data", bus.ret_data, 0);
    chk("rst_rs1_hit", 32'(bus.rs1_hit), 0);
    chk("rst_hazard", 32'(bus.hazard), 0);
    edge_();
    reset = 1;

    // ALU chain
    set_iss(1, 5, 1, 0, 32'h11, 8'h5A); sample(); edge_();
    set_iss(0, 0, 0, 0, 0, 0); bus.rs1_addr = 5;
    sample(); chk("alu_hit", 32'(bus.rs1_hit), 1); chk("alu_data", bus.rs1_data, 32'h11);
    edge_();
    sample(); chk("alu_ret_valid", 32'(bus.ret_valid), 1); chk("alu_ret_rd", 32'(bus.ret_rd), 5);
    edge_();

    // youngest wins
    bus.rs1_addr = 0;
    set_iss(1, 3, 1, 0, 32'hA, 8'h1); sample(); edge_();
    set_iss(1, 3, 1, 0, 32'hB, 8'h2); sample(); edge_();
    set_iss(0, 0, 0, 0, 0, 0); bus.rs2_addr = 3;
    sample(); chk("young_hit", 32'(bus.rs2_hit), 1); chk("young_data", bus.rs2_data, 32'hB);
    edge_();
    bus.rs2_addr = 0;

    // load-use
    set_iss(1, 7, 1, 1, 32'hDEAD, 8'h3); sample(); edge_();
    set_iss(1, 9, 1, 0, 32'h99, 8'h4); bus.rs1_addr = 7;
    sample(); chk("ldu_hazard", 32'(bus.hazard), 1); chk("ldu_nohit", 32'(bus.rs1_hit), 0);
    edge_();
    bus.ld_data = 32'hCAFE;
    sample(); chk("ldu_bubble", 32'(bus.stage_valid), 32'b10); chk("ldu_hazard0", 32'(bus.hazard), 0);
    chk("ldu_hit", 32'(bus.rs1_hit), 1); chk("ldu_data", bus.rs1_data, 32'hCAFE);
    chk("ldu_ret_data", bus.ret_data, 32'hCAFE);
    edge_();
    set_iss(0, 0, 0, 0, 0, 0); bus.rs1_addr = 0; bus.ld_data = 0;
    sample(); edge_();

    // x0
    set_iss(1, 0, 1, 0, 32'hFF, 8'h6); sample(); edge_();
    set_iss(0, 0, 0, 0, 0, 0);
    sample(); chk("x0_nohit", 32'(bus.rs1_hit), 0); edge_();
    sample(); chk("x0_noret", 32'(bus.ret_valid), 0); chk("x0_sv", 32'(bus.stage_valid), 32'b10);
    edge_();

    // stall with full pipe, flush stage0 during stall
    set_iss(1, 1, 1, 0, 32'h101, 8'h7); sample(); edge_();
    set_iss(1, 2, 1, 0, 32'h202, 8'h8); sample(); edge_();
    bus.stall = 1; set_iss(1, 4, 1, 0, 32'h404, 8'h9);
    for (int i = 0; i < 3; i++) begin
      sample(); chk("stall_sv", 32'(bus.stage_valid), 32'b11); chk("stall_noret", 32'(bus.ret_valid), 0);
      edge_();
    end
    bus.flush = 2'b01; sample(); edge_();
    bus.flush = 2'b00;
    sample(); chk("flush_sv", 32'(bus.stage_valid), 32'b10); edge_();
    bus.stall = 0; set_iss(0, 0, 0, 0, 0, 0);
    sample(); chk("unstall_ret", 32'(bus.ret_valid), 1); chk("unstall_rd", 32'(bus.ret_rd), 1);
    edge_();

    // reset mid-stream
    set_iss(1, 6, 1, 0, 32'h66, 8'hA); sample(); edge_();
    set_iss(1, 10, 1, 0, 32'hAA, 8'hB);
    reset = 0; #1;
    chk("arst_sv", 32'(bus.stage_valid), 0); chk("arst_ret", 32'(bus.ret_valid), 0);
    model_clear();
    sample(); edge_();
    reset = 1;
    set_iss(1, 8, 1, 0, 32'h88, 8'hC); sample(); edge_();
    set_iss(0, 0, 0, 0, 0, 0);
    sample(); chk("prst_noret", 32'(bus.ret_valid), 0); edge_();
    sample(); chk("prst_ret", 32'(bus.ret_valid), 1); chk("prst_rd", 32'(bus.ret_rd), 8);
    edge_();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      set_iss($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0, $urandom, CW'($urandom));
      bus.rs1_addr = AW'($urandom_range(0, 7));
      bus.rs2_addr = AW'($urandom_range(0, 7));
      bus.ld_data  = $urandom;
      bus.stall    = $urandom_range(0, 6) == 0;
      bus.flush    = D'($urandom_range(0, 9) == 0 ? $urandom : 0);
      sample(); edge_();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
